// File: rtl/uart_tx_fifo_if.sv
// Handshake and serial-line bundle between the CPU-side UART register and the transmitter.
interface uart_tx_fifo_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data;
   logic                 send;
   logic                 ready;
   logic                 busy;
   logic                 overflow;
   logic                 tx;

   modport master (output data, send, input ready, busy, overflow, tx);
   modport slave  (input data, send, output ready, busy, overflow, tx);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: small TX FIFO, baud divider and frame FSM driving a registered tx pin.
// Define UART_PARITY_EN to insert a parity bit (even, or odd when PARITY_ODD=1) after the data bits.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4,
   parameter int PARITY_ODD   = 0
) (
   input  logic          clk,
   input  logic          reset,
   uart_tx_fifo_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(CLKS_PER_BIT);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] STOP  = 3'd3;
`ifdef UART_PARITY_EN
   localparam logic [2:0] PARITY     = 3'd4;
   localparam logic [2:0] AFTER_DATA = PARITY;
`else
   localparam logic [2:0] AFTER_DATA = STOP;
`endif

   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);

   function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
      return (^d) ^ (PARITY_ODD != 0);
   endfunction

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [AW:0]          count;
   logic [AW:0]          count_next;
   logic [2:0]           state;
   logic [BW-1:0]        baud;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 push;
   logic                 pop;
   logic                 bit_end;
   logic                 not_empty;
   logic                 tx_next;
`ifdef UART_PARITY_EN
   logic                 par_bit;
`endif

   assign not_empty  = (count != '0);
   assign push       = bus.send && bus.ready;
   assign bit_end    = (baud == BAUD_LAST);
   assign count_next = count + (AW + 1)'(push) - (AW + 1)'(pop);

   // Pop either from IDLE or at the very end of the last stop bit, so frames chain with no gap.
   always_comb begin
      pop = 1'b0;
      if (state == IDLE)
         pop = not_empty;
      else if (state == STOP && bit_end && bit_cnt == STOP_LAST)
         pop = not_empty;
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= bus.data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         bus.ready    <= 1'b1;
         bus.overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         count        <= count_next;
         bus.ready    <= (count_next < DEPTH);
         bus.overflow <= bus.send && !bus.ready;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         baud    <= '0;
         bit_cnt <= '0;
      end else begin
         baud <= (state == IDLE || bit_end) ? '0 : baud + BW'(1);
         case (state)
            IDLE: begin
               if (not_empty)
                  state <= START;
            end
            START: begin
               if (bit_end) begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_cnt == DATA_LAST) begin
                     state   <= AFTER_DATA;
                     bit_cnt <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
               if (bit_end) begin
                  state   <= STOP;
                  bit_cnt <= '0;
               end
            end
`endif
            STOP: begin
               if (bit_end) begin
                  if (bit_cnt == STOP_LAST) begin
                     state   <= not_empty ? START : IDLE;
                     bit_cnt <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Datapath registers carry no reset; they are always loaded on pop before use.
   always_ff @(posedge clk) begin
      if (pop) begin
         shreg <= mem[rd_ptr];
`ifdef UART_PARITY_EN
         par_bit <= parity_of(mem[rd_ptr]);
`endif
      end else if (state == DATA && bit_end) begin
         shreg <= shreg >> 1;
      end
   end

   always_comb begin
      tx_next = 1'b1;
      case (state)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shreg[0];
`ifdef UART_PARITY_EN
         PARITY:  tx_next = par_bit;
`endif
         default: tx_next = 1'b1;
      endcase
   end

   // tx and busy are registered from the current state, so both trail the FSM by one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.tx   <= 1'b1;
         bus.busy <= 1'b0;
      end else begin
         bus.tx   <= tx_next;
         bus.busy <= not_empty || (state != IDLE);
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (8N1 even parity, 7-bit/2-stop odd parity) checked against a frame-level model.
module tb_uart_tx_fifo;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       send_v [2];
   logic [8:0] data_v [2];
   logic       tx_v   [2];
   logic       busy_v [2];
   logic       rdy_v  [2];
   logic       ovf_v  [2];

   always #5 clk = ~clk;

   uart_tx_fifo_if #(.DATA_BITS(8)) bus0 ();
   uart_tx_fifo_if #(.DATA_BITS(7)) bus1 ();

   assign bus0.data = data_v[0][7:0];
   assign bus0.send = send_v[0];
   assign bus1.data = data_v[1][6:0];
   assign bus1.send = send_v[1];
   assign tx_v[0]   = bus0.tx;
   assign busy_v[0] = bus0.busy;
   assign rdy_v[0]  = bus0.ready;
   assign ovf_v[0]  = bus0.overflow;
   assign tx_v[1]   = bus1.tx;
   assign busy_v[1] = bus1.busy;
   assign rdy_v[1]  = bus1.ready;
   assign ovf_v[1]  = bus1.overflow;

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(DEPTH),
                  .PARITY_ODD(0)) dut0 (.clk(clk), .reset(rst), .bus(bus0));
   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(DEPTH),
                  .PARITY_ODD(1)) dut1 (.clk(clk), .reset(rst), .bus(bus1));

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Frame-level model: every accepted word gets a scheduled tx start time.
   int         n_acc [2];
   logic [8:0] w_dat [2][64];
   int         w_acc [2][64];
   int         w_st  [2][64];
   logic       m_tx [2], m_busy [2], m_rdy [2], m_ovf [2];

   logic       tr_tx [512], tr_busy [512], tr_rdy [512], tr_ovf [512];
   logic [8:0] seq [8];
   int         nf, bcnt, ovcnt;

   function automatic int db(input int k); return (k == 0) ? 8 : 7; endfunction
   function automatic int sb(input int k); return (k == 0) ? 1 : 2; endfunction
   function automatic int po(input int k); return k; endfunction
   function automatic int fl(input int k); return (1 + db(k) + PB + sb(k)) * CPB; endfunction

   function automatic logic frame_bit(input int k, input logic [8:0] w, input int i);
      int ones;
      ones = 0;
      if (i == 0) return 1'b0;
      if (i <= db(k)) return w[i-1];
      if (PB == 1 && i == db(k) + 1) begin
         for (int j = 0; j < db(k); j++) ones += int'(w[j]);
         return ((ones % 2) == 1) ^ (po(k) == 1);
      end
      return 1'b1;
   endfunction

   function automatic logic [10:0] frame_bits();
      logic [10:0] v;
      for (int i = 0; i < 11; i++) v[i] = tr_tx[3 + 4 * i];
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_edge();
      int t, cnt, j, st, en, prev_end;
      t = cyc;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            n_acc[k] = 0; m_rdy[k] = 1'b1; m_ovf[k] = 1'b0; m_busy[k] = 1'b0; m_tx[k] = 1'b1;
         end else begin
            m_ovf[k] = send_v[k] && !m_rdy[k];
            if (send_v[k] && m_rdy[k] && n_acc[k] < 64) begin
               j = n_acc[k];
               prev_end = (j == 0) ? 0 : w_st[k][j-1] + fl(k);
               w_dat[k][j] = data_v[k];
               w_acc[k][j] = t;
               w_st[k][j]  = (t + 2 > prev_end) ? t + 2 : prev_end;
               n_acc[k]++;
            end
            cnt = 0; m_busy[k] = 1'b0; m_tx[k] = 1'b1;
            for (int i = 0; i < n_acc[k]; i++) begin
               st = w_st[k][i];
               en = st + fl(k);
               if (st - 1 > t) cnt++;
               if (t >= w_acc[k][i] + 1 && t < en) m_busy[k] = 1'b1;
               if (t >= st && t < en) m_tx[k] = frame_bit(k, w_dat[k][i], (t - st) / CPB);
            end
            m_rdy[k] = (cnt < DEPTH);
         end
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("tx%0d", k),       32'(tx_v[k]),   rst ? 32'd1 : 32'(m_tx[k]));
         chk($sformatf("busy%0d", k),     32'(busy_v[k]), rst ? 32'd0 : 32'(m_busy[k]));
         chk($sformatf("ready%0d", k),    32'(rdy_v[k]),  rst ? 32'd1 : 32'(m_rdy[k]));
         chk($sformatf("overflow%0d", k), 32'(ovf_v[k]),  rst ? 32'd0 : 32'(m_ovf[k]));
      end
   endtask

   task automatic step();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      cyc++;
      model_edge();
      #2;
   endtask

   task automatic record(input int k, input int n, inout bit hi);
      tr_tx[n] = tx_v[k]; tr_busy[n] = busy_v[k]; tr_rdy[n] = rdy_v[k]; tr_ovf[n] = ovf_v[k];
      if (ovf_v[k]) ovcnt++;
      if (nf < 0) begin
         if (busy_v[k]) begin hi = 1'b1; bcnt++; end
         else if (hi) nf = n;
      end
   endtask

   // Sends seq[0..nw-1] on consecutive cycles, then traces until busy falls (bounded by maxn).
   task automatic run(input int k, input int nw, input int maxn);
      int e, n;
      bit hi;
      nf = -1; bcnt = 0; ovcnt = 0; hi = 1'b0; e = 0;
      for (int i = 0; i < nw; i++) begin
         send_v[k] = 1'b1; data_v[k] = seq[i];
         step();
         if (i == 0) e = cyc;
         record(k, cyc - e, hi);
      end
      send_v[k] = 1'b0;
      n = cyc - e;
      while (n < maxn && (nf < 0 || n < nf + 4)) begin
         step();
         n = cyc - e;
         record(k, n, hi);
      end
      chk("busy_fall_seen", 32'(nf >= 0), 32'd1);
   endtask

   initial begin
      int e, lows, highs;
      logic [10:0] fb;
      rst = 1'b1;
      send_v[0] = 1'b0; send_v[1] = 1'b0; data_v[0] = '0; data_v[1] = '0;
      repeat (3) step();
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         chk("reset_tx", 32'(tx_v[k]), 32'd1);
         chk("reset_busy", 32'(busy_v[k]), 32'd0);
         chk("reset_ready", 32'(rdy_v[k]), 32'd1);
         chk("reset_overflow", 32'(ovf_v[k]), 32'd0);
      end
      repeat (2) step();

      seq[0] = 9'h0A5;
      run(0, 1, 100);
      chk("a5_tx_idle_at_e1", 32'(tr_tx[1]), 32'd1);
      chk("a5_tx_start_at_e2", 32'(tr_tx[2]), 32'd0);
      fb = frame_bits();
      chk("a5_bits", 32'(fb), (PB == 1) ? 32'b10101001010 : 32'b11101001010);
      chk("a5_busy_cycles", 32'(bcnt), (PB == 1) ? 32'd45 : 32'd41);

      seq[0] = 9'h07F;
      run(1, 1, 100);
      fb = frame_bits();
      chk("7f_bits", 32'(fb), (PB == 1) ? 32'b11011111110 : 32'b11111111110);
      chk("7f_busy_cycles", 32'(bcnt), (PB == 1) ? 32'd45 : 32'd41);
      highs = 0;
      for (int n = nf - 8; n < nf; n++) if (nf >= 8 && tr_tx[n] === 1'b1) highs++;
      chk("7f_stop_high_8", 32'(highs), 32'd8);

      seq[0] = 9'h001; seq[1] = 9'h002; seq[2] = 9'h003;
      run(0, 3, 200);
      chk("b2b_busy_cycles", 32'(bcnt), 32'(3 * fl(0) + 1));
      chk("b2b_last_stop", 32'(tr_tx[1 + fl(0)]), 32'd1);
      chk("b2b_next_start", 32'(tr_tx[2 + fl(0)]), 32'd0);

      for (int i = 0; i < 6; i++) seq[i] = 9'(8'h11 + i);
      run(0, 6, 300);
      chk("ovf_ready_e3", 32'(tr_rdy[3]), 32'd1);
      chk("ovf_ready_e4", 32'(tr_rdy[4]), 32'd0);
      chk("ovf_pulse_e5", 32'(tr_ovf[5]), 32'd1);
      chk("ovf_pulse_count", 32'(ovcnt), 32'd1);
      chk("ovf_frames_busy", 32'(bcnt), 32'(5 * fl(0) + 1));

`ifdef UART_PARITY_EN
      seq[0] = 9'h007;
      run(0, 1, 100);
      fb = frame_bits();
      chk("par_even_07", 32'(fb[9]), 32'd1);
      chk("par_even_len", 32'(bcnt), 32'd45);
      run(1, 1, 100);
      fb = frame_bits();
      chk("par_odd_07", 32'(fb[8]), 32'd0);
      chk("par_odd_len", 32'(bcnt), 32'd45);
`endif

      send_v[0] = 1'b1; data_v[0] = 9'h055; step(); e = cyc;
      data_v[0] = 9'h011; step();
      data_v[0] = 9'h022; step();
      send_v[0] = 1'b0;
      while (cyc - e < 15) step();
      chk("rst_busy_before", 32'(busy_v[0]), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_async_tx", 32'(tx_v[0]), 32'd1);
      chk("rst_async_busy", 32'(busy_v[0]), 32'd0);
      chk("rst_async_ready", 32'(rdy_v[0]), 32'd1);
      repeat (3) step();
      rst = 1'b0;
      lows = 0; highs = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (tx_v[0] !== 1'b1) lows++;
         if (busy_v[0] !== 1'b0) highs++;
      end
      chk("rst_no_tx_after", 32'(lows), 32'd0);
      chk("rst_no_busy_after", 32'(highs), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised UART transmitter with an integrated baud-rate divider and a small transmit FIFO.
- Serialises frames of start, DATA_BITS data (LSB first), optional parity and STOP_BITS stop bits onto tx.
- Sits between the RV32I memory-mapped UART register and the board pin.
- A CPU store writes one word through a send/ready handshake; back-to-back frames go out with no idle gap.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit period (100 MHz / 115200); legal range >= 2
- DATA_BITS, 8, data bits per frame; legal range 5..9
- STOP_BITS, 1, stop bits per frame; 1 or 2
- FIFO_DEPTH, 4, TX FIFO entries; power of two, >= 2
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only when UART_PARITY_EN is defined

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- data  input  DATA_BITS  word to transmit; sampled when send=1 and ready=1
- send  input  1  write strobe, one word per cycle
- ready  output  1  FIFO not full (registered)
- busy  output  1  FIFO non-empty or frame in progress
- overflow  output  1  one-cycle pulse when send=1 while ready=0
- tx  output  1  serial line, idle high

Behaviour:
- Clock and reset: reset is asynchronous and active-high; the clock is clk.
- Reset values: tx=1, busy=0, ready=1, overflow=0. FIFO emptied, FSM in IDLE, baud counter 0, bit counter 0.
- Reset mid-frame: the frame is abandoned, tx returns to 1 immediately, and FIFO contents are discarded.
- FIFO write: send=1 and ready=1 at edge E writes data.
- Dropped writes: send=1 with ready=0 drops the word, leaves the FIFO unchanged, and sets overflow=1 for the cycle after E.
- Simultaneous push and pop: the FIFO supports push and pop in the same cycle, and count is unchanged.
- ready timing: ready reflects count < FIFO_DEPTH after the edge, so a slot freed by a pop is visible one cycle later.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, set the baud counter to 0, and go to START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: tx = shift_reg[0], shifted right at each bit boundary. After DATA_BITS bit periods, go to PARITY if the feature is enabled, else STOP.
- PARITY: tx = parity bit for one bit period.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle cycle); else go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. The bit boundary is when the counter equals CLKS_PER_BIT-1.
- tx is a registered output, glitch-free.
- Latency: send accepted at edge E (FIFO empty, IDLE) -> pop at E+1 -> tx falls at edge E+2.
- Frame length: (1 + DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT cycles, where P = 1 with parity, else 0.
- busy goes high at E+1 and goes low on the edge that ends the last stop bit with the FIFO empty.
- Words shorter than 9 bits: only data[DATA_BITS-1:0] is transmitted.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined: the PARITY state is inserted after DATA.
  - Parity bit = XOR of the DATA_BITS data bits, inverted when PARITY_ODD=1.
  - The parity bit lasts one bit period.
- Not defined: the PARITY state and logic are absent, DATA goes straight to STOP, and PARITY_ODD is ignored.

Test Plan:
- Single frame: CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1, send 0xA5 -> tx falls 2 cycles after send. Each bit is held 4 cycles: 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop). busy high for 41 cycles.
- Back-to-back: send 0x01, 0x02, 0x03 on consecutive cycles -> three contiguous 40-cycle frames, with no idle-high gap between stop and next start. busy drops once, after the third stop bit.
- Overflow: FIFO_DEPTH=4, send 6 words on consecutive cycles -> word 1 is popped, words 2-5 fill the FIFO, and ready=0.
  - The 6th word is dropped with a one-cycle overflow pulse.
  - Exactly 5 frames are transmitted.
- Format: DATA_BITS=7, STOP_BITS=2, send 0x7F -> start 0, seven 1s, then tx high for 8 cycles before busy falls.
- Reset mid-frame: assert reset during the 3rd data bit of 0x55 with 2 words queued -> tx=1, busy=0, ready=1 immediately. No further frames are sent after release.
- Parity (UART_PARITY_EN defined): send 0x07 with PARITY_ODD=0 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0. Frame length is 44 cycles.
